// File: rtl/led_shift_monitor.sv
// Receive-side checker for the 8-LED center-out / outside-in shift display.
// Detects the running sequence, tracks its step, declares lock and counts deviations.
module led_shift_monitor #(
  parameter int LOCK_N = 2
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] LED_IN,
  input  logic       CLR_ERR,
  output logic       MODE_DET,
  output logic [2:0] STEP,
  output logic       LOCKED,
  output logic       ERR,
  output logic [7:0] ERR_CNT,
  output logic       FRAME_DONE
);

  typedef enum logic [0:0] {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [2:0] LOCK_LIM = 3'(LOCK_N);

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  match_q, match_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        frame_done_q, frame_done_d;

  logic [2:0]  nxt_step_s;
  logic [7:0]  expected_s;
  logic [2:0]  match_inc_s;
  logic [7:0]  cnt_pre_s;

  // Pattern at position idx of the selected sequence; index 4 is all-off in both.
  function automatic logic [7:0] seq_val(input logic mode, input logic [2:0] idx);
    logic [7:0] val;
    case ({mode, idx})
      4'b1_000: val = 8'h81;
      4'b1_001: val = 8'h42;
      4'b1_010: val = 8'h24;
      4'b1_011: val = 8'h18;
      4'b0_000: val = 8'h18;
      4'b0_001: val = 8'h24;
      4'b0_010: val = 8'h42;
      4'b0_011: val = 8'h81;
      default:  val = 8'h00;
    endcase
    return val;
  endfunction

  // Successor step index, wrapping 4 -> 0.
  function automatic logic [2:0] step_inc(input logic [2:0] s);
    logic [2:0] r;
    if (s >= 3'd4) begin
      r = 3'd0;
    end else begin
      r = s + 3'd1;
    end
    return r;
  endfunction

  assign nxt_step_s  = step_inc(step_q);
  assign expected_s  = seq_val(mode_q, nxt_step_s);
  assign match_inc_s = (match_q >= LOCK_LIM) ? match_q : match_q + 3'd1;

  // Next-state: prediction check in TRACK, with mismatching samples re-hunted in the same cycle.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    step_d       = step_q;
    match_d      = match_q;
    locked_d     = locked_q;
    err_d        = 1'b0;
    frame_done_d = 1'b0;
    cnt_pre_s    = err_cnt_q;
    if (EN) begin
      if ((state_q == TRACK) && (LED_IN == expected_s)) begin
        step_d       = nxt_step_s;
        match_d      = match_inc_s;
        locked_d     = locked_q | (match_inc_s == LOCK_LIM);
        frame_done_d = (nxt_step_s == 3'd4) & locked_q;
      end else begin
        case (state_q)
          TRACK: begin
            if (locked_q) begin
              err_d     = 1'b1;
              cnt_pre_s = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
            end else begin
              cnt_pre_s = err_cnt_q;
            end
          end
          HUNT:    cnt_pre_s = err_cnt_q;
          default: cnt_pre_s = err_cnt_q;
        endcase
        locked_d = 1'b0;
        if (LED_IN == 8'h81) begin
          state_d = TRACK;
          mode_d  = 1'b1;
          step_d  = 3'd0;
          match_d = 3'd0;
        end else if (LED_IN == 8'h18) begin
          state_d = TRACK;
          mode_d  = 1'b0;
          step_d  = 3'd0;
          match_d = 3'd0;
        end else begin
          state_d = HUNT;
        end
      end
    end else begin
      state_d = state_q;
    end
    if (CLR_ERR) begin
      err_cnt_d = 8'h00;
    end else begin
      err_cnt_d = cnt_pre_s;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q      <= HUNT;
      mode_q       <= 1'b0;
      step_q       <= 3'd0;
      match_q      <= 3'd0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      step_q       <= step_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign MODE_DET   = mode_q;
  assign STEP       = step_q;
  assign LOCKED     = locked_q;
  assign ERR        = err_q;
  assign ERR_CNT    = err_cnt_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_led_shift_monitor.sv
// Directed scoreboard bench for led_shift_monitor (LOCK_N = 2).
module tb_led_shift_monitor;

  logic       Clk;
  logic       RST;
  logic       EN;
  logic [7:0] LED_IN;
  logic       CLR_ERR;
  logic       MODE_DET;
  logic [2:0] STEP;
  logic       LOCKED;
  logic       ERR;
  logic [7:0] ERR_CNT;
  logic       FRAME_DONE;

  int checks = 0;
  int errors = 0;

  // Packed view: {mode, step[2:0], locked, err, cnt[7:0], frame_done}
  logic [14:0] exp_q[$];

  led_shift_monitor #(.LOCK_N(2)) dut (
    .Clk(Clk), .RST(RST), .EN(EN), .LED_IN(LED_IN), .CLR_ERR(CLR_ERR),
    .MODE_DET(MODE_DET), .STEP(STEP), .LOCKED(LOCKED), .ERR(ERR),
    .ERR_CNT(ERR_CNT), .FRAME_DONE(FRAME_DONE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [14:0] mk(input logic m, input logic [2:0] s, input logic l,
                                     input logic e, input logic [7:0] c, input logic f);
    return {m, s, l, e, c, f};
  endfunction

  function automatic logic [14:0] obs();
    return {MODE_DET, STEP, LOCKED, ERR, ERR_CNT, FRAME_DONE};
  endfunction

  task automatic check_out(input string tag);
    logic [14:0] want;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs());
    end else begin
      want = exp_q.pop_front();
      checks++;
      assert (obs() === want) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs(), want);
      end
    end
  endtask

  task automatic cyc(input logic en, input logic [7:0] led, input logic clr,
                     input logic [14:0] want, input string tag);
    @(negedge Clk);
    EN = en;
    LED_IN = led;
    CLR_ERR = clr;
    exp_q.push_back(want);
    @(posedge Clk);
    #1;
    EN = 1'b0;
    CLR_ERR = 1'b0;
    check_out(tag);
  endtask

  task automatic smp(input logic [7:0] led, input logic [14:0] want, input string tag);
    cyc(1'b1, led, 1'b0, want, tag);
  endtask

  initial begin
    logic [7:0] c;
    RST = 1'b1;
    EN = 1'b0;
    LED_IN = 8'h00;
    CLR_ERR = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    check_out("reset");
    @(negedge Clk);
    RST = 1'b0;

    // Mode 1 acquisition, lock, frame completion.
    smp(8'h81, mk(1, 0, 0, 0, 0, 0), "m1_acq");
    smp(8'h42, mk(1, 1, 0, 0, 0, 0), "m1_s1");
    smp(8'h24, mk(1, 2, 1, 0, 0, 0), "m1_lock");
    smp(8'h18, mk(1, 3, 1, 0, 0, 0), "m1_s3");
    smp(8'h00, mk(1, 4, 1, 0, 0, 1), "m1_frame");
    smp(8'h81, mk(1, 0, 1, 0, 0, 0), "m1_wrap");
    cyc(1'b0, 8'h42, 1'b0, mk(1, 0, 1, 0, 0, 0), "idle_hold");

    // Locked error with a non-acquiring value, then re-acquire.
    smp(8'h24, mk(1, 0, 0, 1, 1, 0), "err_hunt");
    cyc(1'b0, 8'h00, 1'b0, mk(1, 0, 0, 0, 1, 0), "err_pulse_end");
    smp(8'h81, mk(1, 0, 0, 0, 1, 0), "reacq");
    smp(8'h42, mk(1, 1, 0, 0, 1, 0), "reacq_s1");
    smp(8'h24, mk(1, 2, 1, 0, 1, 0), "reacq_lock");
    smp(8'h18, mk(1, 3, 1, 0, 1, 0), "m1_s3b");
    smp(8'h00, mk(1, 4, 1, 0, 1, 1), "m1_frame_b");
    smp(8'h81, mk(1, 0, 1, 0, 1, 0), "m1_wrap_b");

    // Locked error with 81 re-acquires immediately.
    smp(8'h81, mk(1, 0, 0, 1, 2, 0), "err_reacq");
    smp(8'h42, mk(1, 1, 0, 0, 2, 0), "err_reacq_s1");
    smp(8'h24, mk(1, 2, 1, 0, 2, 0), "err_reacq_lock");

    // Asynchronous reset while locked at step 2.
    @(negedge Clk);
    RST = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    check_out("async_rst");
    @(negedge Clk);
    RST = 1'b0;
    smp(8'h00, mk(0, 0, 0, 0, 0, 0), "post_rst_00a");
    smp(8'h00, mk(0, 0, 0, 0, 0, 0), "post_rst_00b");

    // Mode 0 stream entered mid-sequence.
    smp(8'h42, mk(0, 0, 0, 0, 0, 0), "m0_hunt42");
    smp(8'h81, mk(1, 0, 0, 0, 0, 0), "m0_false_acq");
    smp(8'h00, mk(1, 0, 0, 0, 0, 0), "m0_unlocked_miss");
    smp(8'h18, mk(0, 0, 0, 0, 0, 0), "m0_acq");
    smp(8'h24, mk(0, 1, 0, 0, 0, 0), "m0_s1");
    smp(8'h42, mk(0, 2, 1, 0, 0, 0), "m0_lock");

    // 300 locked errors: count saturates at 255.
    for (int i = 1; i <= 300; i++) begin
      c = (i > 255) ? 8'hFF : 8'(i);
      smp(8'h24, mk(0, 2, 0, 1, c, 0), "sat_err");
      smp(8'h18, mk(0, 0, 0, 0, c, 0), "sat_acq");
      smp(8'h24, mk(0, 1, 0, 0, c, 0), "sat_s1");
      smp(8'h42, mk(0, 2, 1, 0, c, 0), "sat_lock");
    end

    // Clear wins over a simultaneous counted error, ERR still pulses.
    cyc(1'b1, 8'h24, 1'b1, mk(0, 2, 0, 1, 0, 0), "clr_vs_err");
    cyc(1'b0, 8'h00, 1'b0, mk(0, 2, 0, 0, 0, 0), "clr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_shift_monitor.md
# led_shift_monitor

Receive-side checker for the 8-LED center-out / outside-in shift display. It samples the 8-bit LED bus once per strobe and works out which of the two shift sequences is running. It then tracks the step position, declares lock after consecutive correct predictions, and flags and counts any deviation. It sits next to the LED shift generator in self-checking builds, or on a board test header.

## Interface

Parameters:
- LOCK_N, default 2: number of consecutive correct predictions after acquisition before LOCKED asserts (1..7).

Ports:
- Clk  input  1  system clock; all logic is rising-edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  sample strobe; high for one Clk when LED_IN holds a new pattern (mirrors the generator's advance enable).
- LED_IN  input  8  LED pattern under observation.
- CLR_ERR  input  1  synchronous clear of ERR_CNT.
- MODE_DET  output  1  detected sequence: 1 = outside-in, 0 = center-out; valid while TRACK.
- STEP  output  3  index 0..4 of the last accepted pattern within the detected sequence.
- LOCKED  output  1  sequence locked.
- ERR  output  1  one-cycle pulse on a mismatch while LOCKED.
- ERR_CNT  output  8  saturating mismatch count.
- FRAME_DONE  output  1  one-cycle pulse when step 4 (all-off) is accepted while LOCKED.

## Operation

Sequences (hex, index 0..4, wrapping 4 -> 0):
- Mode 1 (outside-in): 81, 42, 24, 18, 00.
- Mode 0 (center-out): 18, 24, 42, 81, 00.

The FSM has two states, HUNT and TRACK. Only EN cycles change state or counters; non-EN cycles hold everything, and ERR and FRAME_DONE are 0.

HUNT:
- Sample 81 -> TRACK, MODE_DET=1, STEP=0, match_cnt=0.
- Sample 18 -> TRACK, MODE_DET=0, STEP=0, match_cnt=0.
- Any other sample, including 00 -> stay in HUNT.

TRACK:
- Expected value = sequence[MODE_DET][(STEP+1) mod 5].
- On match:
  - STEP advances.
  - match_cnt increments, saturating at LOCK_N.
  - LOCKED sets when match_cnt reaches LOCK_N.
  - If the new STEP is 4 and LOCKED is already 1 before this sample, FRAME_DONE pulses.
- On mismatch:
  - If LOCKED, ERR pulses and ERR_CNT increments, saturating at 255.
  - LOCKED clears.
  - The same sample is re-evaluated under the HUNT rules in the same cycle. For example, 81 re-acquires mode 1 at STEP=0 immediately; any other value goes to HUNT.
  - A mismatch while not yet locked only re-hunts and is never counted.

Other rules:
- CLR_ERR sets ERR_CNT to 0. If CLR_ERR and a counted error occur in the same cycle, CLR_ERR wins (ERR_CNT=0), but ERR still pulses.
- A repeated identical sample (for example, a generator paused but EN still strobed) is a mismatch. EN must only accompany real advances.
- MODE_DET and STEP hold their last values in HUNT; they are don't-care to consumers while LOCKED=0.

## Timing

- All outputs are registered and update on the Clk edge that samples EN=1; latency is 1 cycle from the sample.
- RST forces: state HUNT, MODE_DET=0, STEP=0, LOCKED=0, ERR=0, ERR_CNT=0, FRAME_DONE=0, match_cnt=0.
- RST asserted mid-sequence aborts immediately. After release, the monitor re-acquires from the next 81 or 18 sample.
- LOCKED asserts on the EN edge of the LOCK_N-th correct prediction. With LOCK_N=2 this is the 3rd sample counting the acquiring one.
- Worst-case acquisition with an ideal stream: up to 4 samples of hunting, plus 1 acquiring sample, plus LOCK_N predicted samples.

## Test plan

- Reset, then feed mode 1 stream 81,42,24,18,00,81 with LOCK_N=2 -> LOCKED=1 after the 24 sample; FRAME_DONE pulses on the 00 sample; STEP ends at 0; ERR_CNT=0.
- Mode 0 stream starting mid-sequence (42,81,00,18,24,42) -> hunts through 42,81 (81 acquires mode 1, then 00 matches mode 1 index 1? No: expected 42, so mismatch, unlocked, no count); 18 acquires mode 0; LOCKED after 42; MODE_DET=0.
- Locked mode 1, then inject 24 where 42 is expected -> ERR pulse, ERR_CNT=1, LOCKED=0, state HUNT. The next 81 re-acquires.
- Locked mode 1, then inject 81 where 42 is expected -> ERR pulse and immediate re-acquisition at STEP=0; LOCKED returns after 2 more correct samples.
- Force 300 locked errors (error, re-lock, repeat) -> ERR_CNT saturates at 255. Then CLR_ERR in the same cycle as an error -> ERR_CNT=0 and ERR=1.
- RST pulse while locked at STEP=2 -> all outputs 0 asynchronously; EN samples with LED_IN=00 keep the monitor in HUNT.
